// File: rtl/pixel_scanner.sv
// pixel_scanner: VGA-style raster timing generator that scans a 2x-scaled
// 2-bit-per-pixel frame buffer and produces colour, sync and enable outputs.
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rst_n        in   synchronous active-low reset
//   mem_addr     out  [N-1:0] pixel read address: row in upper half, column in lower half
//   mem_data     in   [N-1:0] read data, valid one clk after mem_addr; only [1:0] used
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   rgb          out  [23:0] pixel colour {R,G,B}
//   de           out  display enable, high for visible pixels
//   frame_start  out  one-clk pulse when the raster wraps back to (0,0)
//
// Pipeline: on tick k the counters hold position P(k). mem_addr for P(k) is
// registered on that tick, the memory answers before the next tick, and on
// tick k+1 the colour plus the sync/enable flags for P(k) are registered
// together, so rgb/hsync/vsync/de always describe the same pixel.
module pixel_scanner #(
  parameter int          N       = 32,
  parameter int          PIX_DIV = 2,
  parameter int          H_VIS   = 640,
  parameter int          H_FP    = 16,
  parameter int          H_SYNC  = 96,
  parameter int          H_BP    = 48,
  parameter int          V_VIS   = 480,
  parameter int          V_FP    = 10,
  parameter int          V_SYNC  = 2,
  parameter int          V_BP    = 33,
  parameter logic [23:0] PAL0    = 24'h000000,
  parameter logic [23:0] PAL1    = 24'hFF0000,
  parameter logic [23:0] PAL2    = 24'h00FF00,
  parameter logic [23:0] PAL3    = 24'hFFFFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [N-1:0]  mem_addr,
  input  logic [N-1:0]  mem_data,
  output logic          hsync,
  output logic          vsync,
  output logic [23:0]   rgb,
  output logic          de,
  output logic          frame_start
);

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_W      = $clog2(H_TOT);
  localparam int V_W      = $clog2(V_TOT);
  localparam int DIV_W    = $clog2(PIX_DIV);
  localparam int HALF     = N / 2;
  localparam int HS_FIRST = H_VIS + H_FP;
  localparam int HS_LAST  = H_VIS + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_VIS + V_FP;
  localparam int VS_LAST  = V_VIS + V_FP + V_SYNC - 1;

  logic [DIV_W-1:0] div;
  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic [H_W-1:0]   h_d;
  logic [V_W-1:0]   v_d;
  logic             vis_d;

  logic             tick;
  logic             h_last;
  logic             v_last;
  logic             vis;
  logic             hs_act;
  logic             vs_act;
  logic [HALF-1:0]  row;
  logic [HALF-1:0]  col;
  logic [23:0]      pal;

  // Upper data bits carry nothing for a 2-bit pixel format.
  logic             unused_mem_bits;
  assign unused_mem_bits = ^mem_data[N-1:2];

  assign tick   = (div == DIV_W'(PIX_DIV - 1));
  assign h_last = (h_cnt == H_W'(H_TOT - 1));
  assign v_last = (v_cnt == V_W'(V_TOT - 1));
  assign vis    = (h_cnt < H_W'(H_VIS)) && (v_cnt < V_W'(V_VIS));

  // Sync windows are decoded from the delayed position so they line up with rgb.
  assign hs_act = (h_d >= H_W'(HS_FIRST)) && (h_d <= H_W'(HS_LAST));
  assign vs_act = (v_d >= V_W'(VS_FIRST)) && (v_d <= V_W'(VS_LAST));

  // 2x scaling: each source pixel covers a 2x2 block of display positions.
  assign row = HALF'(v_cnt >> 1);
  assign col = HALF'(h_cnt >> 1);

  always_comb begin
    pal = PAL0;
    case (mem_data[1:0])
      2'd0:    pal = PAL0;
      2'd1:    pal = PAL1;
      2'd2:    pal = PAL2;
      default: pal = PAL3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div         <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_d         <= '0;
      v_d         <= '0;
      vis_d       <= 1'b0;
      mem_addr    <= '0;
      rgb         <= 24'h000000;
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        div <= '0;
      end else begin
        div <= div + DIV_W'(1);
      end

      if (tick) begin
        // Raster counters
        if (h_last) begin
          h_cnt <= '0;
          if (v_last) begin
            v_cnt <= '0;
          end else begin
            v_cnt <= v_cnt + V_W'(1);
          end
        end else begin
          h_cnt <= h_cnt + H_W'(1);
        end
        frame_start <= h_last && v_last;

        // Fetch stage: address held through blanking so the memory sees no churn.
        if (vis) begin
          mem_addr <= N'({row, col});
        end
        h_d   <= h_cnt;
        v_d   <= v_cnt;
        vis_d <= vis;

        // Output stage for the position fetched on the previous tick.
        rgb   <= vis_d ? pal : 24'h000000;
        de    <= vis_d;
        hsync <= ~hs_act;
        vsync <= ~vs_act;
      end
    end
  end

endmodule

// File: tb/tb_pixel_scanner.sv
// Bench for pixel_scanner using a reduced raster (24x10 ticks per frame) so
// whole frames fit in a short run. Expected per-tick output words are queued
// before each scan starts; a negedge monitor pops one word per tick, checks
// the in-between clk for hold, and logs sync/frame edges for timing checks.
module tb_pixel_scanner;

  localparam int N       = 32;
  localparam int PIX_DIV = 2;
  localparam int H_VIS   = 16;
  localparam int H_FP    = 2;
  localparam int H_SYNC  = 3;
  localparam int H_BP    = 3;
  localparam int V_VIS   = 6;
  localparam int V_FP    = 1;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 1;
  localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;  // 24
  localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;  // 10

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  mem_addr;
  logic [N-1:0]  mem_data = '0;
  logic          hsync;
  logic          vsync;
  logic [23:0]   rgb;
  logic          de;
  logic          frame_start;

  always #5 clk = ~clk;

  pixel_scanner #(
    .N(N), .PIX_DIV(PIX_DIV),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .hsync(hsync),
    .vsync(vsync),
    .rgb(rgb),
    .de(de),
    .frame_start(frame_start)
  );

  // Memory model: code = (column + row) mod 4, one clk read latency.
  always @(posedge clk) begin
    mem_data <= {30'd0, mem_addr[1:0] + mem_addr[17:16]};
  end

  // ---------------- scoreboard state ----------------
  // word = {mem_addr[59:28], rgb[27:4], de[3], hsync[2], vsync[1], frame_start[0]}
  logic [59:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [23:0] pal_tb [4] = '{24'h000000, 24'hFF0000, 24'h00FF00, 24'hFFFFFF};
  localparam logic [59:0] RESET_WORD = {32'd0, 24'd0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: expected stream for a scan from reset ----------------
  task automatic push_scan(input int count);
    logic [31:0] last_addr;
    logic [23:0] e_rgb;
    logic        e_de, e_hs, e_vs, e_fs;
    int h, v, ph, pv;
    last_addr = 32'd0;
    for (int k = 0; k < count; k++) begin
      h = k % H_TOT;
      v = (k / H_TOT) % V_TOT;
      if (h < H_VIS && v < V_VIS) last_addr = 32'((v / 2) * 65536 + (h / 2));
      e_fs = (h == H_TOT - 1) && (v == V_TOT - 1);
      if (k == 0) begin
        e_rgb = 24'd0; e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
      end else begin
        ph = (k - 1) % H_TOT;
        pv = ((k - 1) / H_TOT) % V_TOT;
        e_de  = (ph < H_VIS) && (pv < V_VIS);
        e_rgb = e_de ? pal_tb[((ph / 2) + (pv / 2)) % 4] : 24'd0;
        e_hs  = !(ph >= H_VIS + H_FP && ph <= H_VIS + H_FP + H_SYNC - 1);
        e_vs  = !(pv >= V_VIS + V_FP && pv <= V_VIS + V_FP + V_SYNC - 1);
      end
      exp_q.push_back({last_addr, e_rgb, e_de, e_hs, e_vs, e_fs});
    end
  endtask

  // Hand-computed spot values at particular tick indices.
  task automatic directed(input int k, input logic [59:0] got);
    case (k)
      1:   check("dir_rgb_code0",  got[27:3], {24'h000000, 1'b1});
      3:   check("dir_rgb_code1",  got[27:3], {24'hFF0000, 1'b1});
      7:   check("dir_rgb_code3",  got[27:3], {24'hFFFFFF, 1'b1});
      75:  check("dir_rgb_code2",  got[27:3], {24'h00FF00, 1'b1});
      18:  check("dir_rgb_blank",  got[27:3], {24'h000000, 1'b0});
      16:  check("dir_addr_hold",  got[59:28], 32'h0000_0007);
      74:  check("dir_addr_2_3",   got[59:28], 32'h0001_0001);
      135: check("dir_addr_last",  got[59:28], 32'h0002_0007);
      239: check("dir_addr_vblank", got[59:28], 32'h0002_0007);
      default: ;
    endcase
  endtask

  // ---------------- monitor ----------------
  logic        rst_q_tb = 1'b0;
  bit          seen = 1'b0;
  int          cyc = 0;
  logic [59:0] got;
  logic [59:0] last_exp;
  bit          have_last = 1'b0;
  logic        p_hs = 1'b1, p_vs = 1'b1, p_fs = 1'b0;
  int          hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_rise[$];

  always @(posedge clk) begin
    rst_q_tb <= rst_n;
    seen     <= 1'b1;
  end

  always @(negedge clk) begin
    got = {mem_addr, rgb, de, hsync, vsync, frame_start};
    if (!rst_q_tb) begin
      if (seen) check("reset_state", 64'(got), 64'(RESET_WORD));
      cyc = 0;
      have_last = 1'b0;
      p_hs = 1'b1; p_vs = 1'b1; p_fs = 1'b0;
      hs_fall.delete(); hs_rise.delete();
      vs_fall.delete(); vs_rise.delete(); fs_rise.delete();
    end else begin
      cyc++;
      if (cyc == 1) begin
        check("before_first_tick", 64'(got), 64'(RESET_WORD));
      end else if (cyc % 2 == 0) begin
        if (exp_q.size() > 0) begin
          last_exp = exp_q.pop_front();
          check("tick_outputs", 64'(got), 64'(last_exp));
          have_last = 1'b1;
          directed(cyc / 2 - 1, got);
        end else begin
          have_last = 1'b0;
        end
      end else if (have_last) begin
        check("hold_between_ticks", 64'(got), 64'({last_exp[59:1], 1'b0}));
      end
      if (p_hs && !hsync) hs_fall.push_back(cyc);
      if (!p_hs && hsync) hs_rise.push_back(cyc);
      if (p_vs && !vsync) vs_fall.push_back(cyc);
      if (!p_vs && vsync) vs_rise.push_back(cyc);
      if (!p_fs && frame_start) fs_rise.push_back(cyc);
      p_hs = hsync; p_vs = vsync; p_fs = frame_start;
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clk);
    check("scan_drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a, b;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);

    // Scan 1: 340 ticks, ending mid-frame on line 4.
    push_scan(340);
    rst_n = 1'b1;
    wait_drain();

    // Line timing, counted in clks from reset release (first tick at clk 2).
    a = (hs_fall.size() > 0) ? hs_fall[0] : -1;
    check("hsync_first_fall", 64'(a), 64'd40);
    b = (hs_fall.size() > 1) ? hs_fall[1] : -1;
    check("hsync_period", 64'(b - a), 64'd48);
    b = (hs_rise.size() > 0) ? hs_rise[0] : -1;
    check("hsync_low_width", 64'(b - a), 64'd6);
    a = (vs_fall.size() > 0) ? vs_fall[0] : -1;
    check("vsync_first_fall", 64'(a), 64'd340);
    b = (vs_rise.size() > 0) ? vs_rise[0] : -1;
    check("vsync_low_width", 64'(b - a), 64'd96);

    // Mid-frame reset for 3 clks, then a fresh scan from (0,0).
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    push_scan(600);
    rst_n = 1'b1;
    wait_drain();

    a = (fs_rise.size() > 0) ? fs_rise[0] : -1;
    check("frame_start_after_release", 64'(a), 64'd480);
    b = (fs_rise.size() > 1) ? fs_rise[1] : -1;
    check("frame_start_spacing", 64'(b - a), 64'd480);
    a = (hs_fall.size() > 0) ? hs_fall[0] : -1;
    check("hsync_first_fall_after_reset", 64'(a), 64'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
